// File: rtl/cic_sample_buffer.sv
// Decimation strobe, CIC3 settling discard, round/saturate and show-ahead output FIFO
// for the cic3_echip65 output path.
module cic_sample_buffer #(
  parameter int IN_WIDTH   = 25,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 9,
  parameter int DECIMATION = 64,
  parameter int DISCARD    = 3,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [IN_WIDTH-1:0]      cic_in,
  output logic                     sample_strobe,
  output logic                     rd_valid,
  output logic [OUT_WIDTH-1:0]     rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [1:0]               fsm_state
);

  // Read handshake: rd_valid/rd_data present the FIFO head; a word is consumed in
  // every cycle where rd_valid && rd_ready at the rising edge; rd_valid never waits on rd_ready.

  typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, RUN = 2'd2} state_t;

  localparam int CW   = $clog2(DECIMATION);
  localparam int DW   = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0]   CNT_MAX   = CW'(DECIMATION - 1);
  localparam logic [DW-1:0]   DISC_LAST = DW'(DISCARD - 1);
  localparam logic [AW-1:0]   PTR_MAX   = AW'(DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DEPTH);

  localparam logic signed [IN_WIDTH:0] HALF    = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MAX = ({{IN_WIDTH{1'b0}}, 1'b1} << (OUT_WIDTH - 1)) - 1'b1;
  localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

  logic [CW-1:0]  cnt;
  state_t         state, state_next;
  logic [DW-1:0]  disc, disc_next;
  logic           capture;

  // Decimation counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            cnt <= '0;
    else if (!enable)        cnt <= '0;
    else if (cnt == CNT_MAX) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign sample_strobe = enable && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      disc  <= '0;
    end else begin
      state <= state_next;
      disc  <= disc_next;
    end
  end

  always_comb begin
    state_next = state;
    disc_next  = disc;
    capture    = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          disc_next  = '0;
          state_next = (DISCARD == 0) ? RUN : WARMUP;
        end
        WARMUP: begin
          if (sample_strobe) begin
            disc_next = disc + 1'b1;
            if (disc == DISC_LAST) state_next = RUN;
          end
        end
        RUN:     capture = sample_strobe;
        default: state_next = IDLE;
      endcase
    end
  end

  assign fsm_state = state;

  // Round half-up then arithmetic shift, one extra bit so the rounding add cannot wrap
  logic signed [IN_WIDTH:0] sum_w, shifted;
  logic [OUT_WIDTH-1:0]     sat_val;

  always_comb begin
    sum_w   = $signed({cic_in[IN_WIDTH-1], cic_in}) + HALF;
    shifted = sum_w >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
    else                        sat_val = shifted[OUT_WIDTH-1:0];
  end

  logic                 pipe_valid;
  logic [OUT_WIDTH-1:0] pipe_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= capture;
      if (capture) pipe_data <= sat_val;
    end
  end

  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr, rd_ptr_inc;
  logic                 pop, full, wr_en, drop;

  assign rd_valid   = (fifo_count != '0);
  assign pop        = rd_valid && rd_ready;
  assign full       = (fifo_count == CNT_FULL);
  assign wr_en      = pipe_valid && (!full || pop);
  assign drop       = pipe_valid && full && !pop;
  assign rd_ptr_inc = (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= pipe_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr_inc;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // Registered head: refreshed from the incoming word when it becomes the head,
  // otherwise from the next slot on a pop; held while the FIFO is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (pop) begin
      if (fifo_count == CNTW'(1)) begin
        if (wr_en) rd_data <= pipe_data;
      end else begin
        rd_data <= mem[rd_ptr_inc];
      end
    end else if (!rd_valid && wr_en) begin
      rd_data <= pipe_data;
    end
  end

endmodule

// File: tb/tb_cic_sample_buffer.sv
// Randomized and directed stimulus for cic_sample_buffer; a negedge monitor checks
// outputs against a queue-based reference of strobes, discards and FIFO contents.
module tb_cic_sample_buffer;

  localparam int IN_W    = 25;
  localparam int OUT_W   = 16;
  localparam int SHIFT   = 9;
  localparam int DEC     = 64;
  localparam int DISCARD = 3;
  localparam int DEPTH   = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [IN_W-1:0]   cic_in;
  logic              sample_strobe;
  logic              rd_valid;
  logic [OUT_W-1:0]  rd_data;
  logic              rd_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              overflow;
  logic              overflow_clr;
  logic [1:0]        fsm_state;

  // clock / reset
  always #5 clk = ~clk;

  cic_sample_buffer #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(SHIFT),
    .DECIMATION(DEC), .DISCARD(DISCARD), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cic_in(cic_in),
    .sample_strobe(sample_strobe), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .fifo_count(fifo_count), .overflow(overflow),
    .overflow_clr(overflow_clr), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: round half-up, floor divide, clamp -- plain integer arithmetic
  function automatic logic [OUT_W-1:0] ref_sample(input logic [IN_W-1:0] x);
    longint v, r, q, hi, lo;
    v = longint'(x);
    if (x[IN_W-1]) v = v - (longint'(1) << IN_W);
    r = v + (longint'(1) << (SHIFT - 1));
    if (r >= 0) q = r / (longint'(1) << SHIFT);
    else        q = -((-r + (longint'(1) << SHIFT) - 1) / (longint'(1) << SHIFT));
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[OUT_W-1:0];
  endfunction

  // scoreboard state
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] last_head = '0;
  logic [OUT_W-1:0] pend_val  = '0;
  bit               pend_v    = 0;
  bit               m_ovf     = 0;
  int               en_cycles = 0;

  always @(negedge clk) begin
    int cur_en;
    bit exp_strobe, pop, full_before, set_ovf;
    logic [OUT_W-1:0] head;
    if (!reset_n) begin
      exp_q.delete();
      m_ovf = 0; pend_v = 0; en_cycles = 0; last_head = '0;
      chk("reset_count",  32'(fifo_count),    0);
      chk("reset_valid",  32'(rd_valid),      0);
      chk("reset_ovf",    32'(overflow),      0);
      chk("reset_strobe", 32'(sample_strobe), 0);
      chk("reset_data",   32'(rd_data),       0);
      chk("reset_state",  32'(fsm_state),     0);
    end else begin
      cur_en     = enable ? en_cycles + 1 : 0;
      exp_strobe = enable && (cur_en % DEC == 0);
      head       = (exp_q.size() != 0) ? exp_q[0] : last_head;
      chk("strobe",   32'(sample_strobe), 32'(exp_strobe));
      chk("count",    32'(fifo_count),    32'(exp_q.size()));
      chk("valid",    32'(rd_valid),      32'(exp_q.size() != 0));
      chk("overflow", 32'(overflow),      32'(m_ovf));
      chk("rd_data",  32'(rd_data),       32'(head));
      last_head   = head;
      pop         = rd_ready && (exp_q.size() != 0);
      full_before = (exp_q.size() == DEPTH);
      if (pop) void'(exp_q.pop_front());
      set_ovf = 0;
      if (pend_v) begin
        if (full_before && !pop) set_ovf = 1;
        else exp_q.push_back(pend_val);
      end
      if (set_ovf)           m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      // Only strobes beyond the settling count since the last enable rise are kept
      pend_v    = exp_strobe && (cur_en / DEC > DISCARD);
      pend_val  = ref_sample(cic_in);
      en_cycles = cur_en;
    end
  end

  // driver tasks
  task automatic drive(input logic en, input logic [IN_W-1:0] d, input logic rdy, input logic clr);
    enable = en; cic_in = d; rd_ready = rdy; overflow_clr = clr;
    @(posedge clk); #1;
  endtask

  function automatic logic [IN_W-1:0] rand_cic();
    int sel, v;
    sel = $urandom_range(0, 3);
    if (sel == 0) return IN_W'($urandom());
    if (sel == 1) return IN_W'(32'h0FFFE00 + $urandom_range(0, 511));
    v = int'($urandom_range(0, 32'h00FFFFFF)) - 32'sh00800000;
    return IN_W'(v);
  endfunction

  // One decimation period, aligned so its strobe lands in the last cycle
  task automatic window(input logic [IN_W-1:0] d, input logic rdy_first, input logic rdy_rest,
                        input int clr_at);
    for (int i = 0; i < DEC; i++)
      drive(1'b1, d, (i == 0) ? rdy_first : rdy_rest, i == clr_at);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; cic_in = '0; rd_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Fill to five entries, then reset mid-run
    for (int w = 0; w < DISCARD + 5; w++) window(rand_cic(), 1'b0, 1'b0, -1);
    drive(1'b1, rand_cic(), 1'b0, 1'b0);
    drive(1'b1, rand_cic(), 1'b0, 1'b0);
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Constant 256 -> 0x0001 after the settling strobes
    for (int w = 0; w < DISCARD + 3; w++) window(IN_W'(256), 1'b1, 1'b1, -1);

    // Saturation and rounding corners
    window(IN_W'(32'h0FFFFFF), 1'b1, 1'b1, -1);
    window(IN_W'(32'h1000000), 1'b1, 1'b1, -1);
    window(IN_W'(32'h1FFFE00), 1'b1, 1'b1, -1);
    window(IN_W'(32'h00000FF), 1'b1, 1'b1, -1);
    window(IN_W'(32'h00000FF), 1'b1, 1'b1, -1);

    // Stall until overflow; clear coinciding with a drop must lose, later clear wins
    for (int w = 0; w < 10; w++) window(rand_cic(), 1'b0, 1'b0, -1);
    window(rand_cic(), 1'b0, 1'b0, 0);
    window(rand_cic(), 1'b0, 1'b0, 10);

    // Full FIFO, pop on the push cycle: count stays, no overflow
    for (int w = 0; w < 3; w++) window(rand_cic(), 1'b1, 1'b0, -1);

    // Drain, then drop enable mid-warmup and re-enable
    for (int i = 0; i < 20; i++) drive(1'b0, rand_cic(), 1'b1, 1'b0);
    window(rand_cic(), 1'b1, 1'b1, -1);
    window(rand_cic(), 1'b1, 1'b1, -1);
    for (int i = 0; i < 5; i++) drive(1'b0, rand_cic(), 1'b1, 1'b0);
    for (int w = 0; w < DISCARD + 2; w++) window(rand_cic(), 1'b1, 1'b1, -1);

    // Random bursts with random backpressure and clears
    for (int b = 0; b < 16; b++) begin
      int len, gap, stall;
      len   = $urandom_range(40, 450);
      gap   = $urandom_range(1, 12);
      stall = $urandom_range(0, 1);
      for (int i = 0; i < len; i++)
        drive(1'b1, rand_cic(),
              stall != 0 ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
              $urandom_range(0, 40) == 0);
      for (int i = 0; i < gap; i++)
        drive(1'b0, rand_cic(), 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b1, 1'b1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
